// File: rtl/counters.sv
// Edge-qualified event counter: resynchronizes an asynchronous pulse, detects
// the selected edge(s) and advances a modulo or saturating count.
module counters #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int SATURATE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,
    output logic [WIDTH-1:0] counter
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [WIDTH-1:0]       counter_q, counter_d;
    logic                   sync, rise, fall, evt;

    always_comb begin
        sync_d    = '0;
        sync_d[0] = pulse;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign hist_d = sync;
    assign rise   = sync & ~hist_q;
    assign fall   = ~sync & hist_q;

    // Unlisted edge modes fall back to rising-edge counting.
    always_comb begin
        case (EDGE_MODE)
            1:       evt = fall;
            2:       evt = rise | fall;
            default: evt = rise;
        endcase
    end

    always_comb begin
        counter_d = counter_q;
        if (evt) begin
            if (counter_q == MAX_CNT) begin
                counter_d = (SATURATE != 0) ? MAX_CNT : '0;
            end else begin
                counter_d = counter_q + WIDTH'(1);
            end
        end
    end

    // Reset loads the live pulse level everywhere so a steady level across
    // reset release cannot look like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {SYNC_STAGES{pulse}};
            hist_q    <= pulse;
            counter_q <= '0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            counter_q <= counter_d;
        end
    end

    assign counter = counter_q;

endmodule

// File: tb/tb_counters.sv
// Directed bench for counters: several parameterizations driven by one
// shared pulse/reset stimulus, each checked against hand-computed counts.
module tb_counters;

    logic       clk;
    logic       rst;
    logic       pulse;
    logic [3:0] c_def, c_sat, c_m10, c_both, c_fall, c_s3;

    int n_cmp = 0;
    int n_err = 0;

    counters u_def (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_def));
    counters #(.SATURATE(1)) u_sat (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_sat));
    counters #(.MODULUS(10)) u_m10 (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_m10));
    counters #(.EDGE_MODE(2)) u_both (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_both));
    counters #(.EDGE_MODE(1)) u_fall (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_fall));
    counters #(.SYNC_STAGES(3)) u_s3 (.clk(clk), .rst(rst), .pulse(pulse), .counter(c_s3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rise2();
        pulse = 1'b1;
        tick(2);
        pulse = 1'b0;
        tick(2);
    endtask

    initial begin
        rst   = 1'b1;
        pulse = 1'b1;
        #1;

        // Reset with pulse held high, then release with pulse still high.
        tick(2);
        chk("rst_def", int'(c_def), 0);
        chk("rst_fall", int'(c_fall), 0);
        rst = 1'b0;
        tick(4);
        chk("rel_def", int'(c_def), 0);
        chk("rel_both", int'(c_both), 0);
        chk("rel_s3", int'(c_s3), 0);

        // Single one-clock-wide rise: counts on the 3rd edge (4th with 3 stages).
        pulse = 1'b0;
        tick(4);
        do_reset();
        tick(2);
        pulse = 1'b1;
        tick();                    // edge 1 samples pulse=1
        pulse = 1'b0;
        chk("lat_e1", int'(c_def), 0);
        tick();
        chk("lat_e2", int'(c_def), 0);
        tick();
        chk("lat_e3", int'(c_def), 1);
        chk("lat_s3_e3", int'(c_s3), 0);
        tick();
        chk("lat_s3_e4", int'(c_s3), 1);
        tick(4);
        chk("no_fall_def", int'(c_def), 1);

        // Sixteen clean rising edges: wrap, saturate, modulus 10.
        do_reset();
        tick(2);
        for (int k = 1; k <= 16; k++) begin
            rise2();
            chk($sformatf("wrap_%0d", k), int'(c_def), k % 16);
            chk($sformatf("sat_%0d", k), int'(c_sat), (k > 15) ? 15 : k);
            chk($sformatf("m10_%0d", k), int'(c_m10), k % 10);
            chk($sformatf("s3_%0d", k), int'(c_s3), k % 16);
        end

        // 0->1->0->1 at 3-clock spacing across edge modes.
        do_reset();
        tick(2);
        pulse = 1'b1;
        tick(3);
        pulse = 1'b0;
        tick(3);
        pulse = 1'b1;
        tick(3);
        tick(3);
        chk("mode_both", int'(c_both), 3);
        chk("mode_fall", int'(c_fall), 1);
        chk("mode_rise", int'(c_def), 2);

        // Mid-count reset coinciding with a detected rise.
        pulse = 1'b0;
        tick(3);
        do_reset();
        tick(2);
        for (int k = 0; k < 5; k++) rise2();
        chk("mid_pre", int'(c_def), 5);
        pulse = 1'b1;
        tick(2);                   // rise now detected in the current cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", int'(c_def), 0);
        tick(3);
        chk("mid_hold", int'(c_def), 0);
        pulse = 1'b0;
        tick(2);
        pulse = 1'b1;
        tick(3);
        chk("mid_after", int'(c_def), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
